// File: rtl/pm_boot_loader_if.sv
// Boot loader bus bundle: incoming byte stream (valid/ready) and the program memory
// write port (pmWrEn / pm_addr / instructionIn).
// slave  : the loader's view (sinks the stream, drives the memory write port).
// master : the environment's view (sources the stream, observes the memory writes).
interface pm_boot_loader_if #(
  parameter int unsigned AddWidth  = 7,
  parameter int unsigned DataWidth = 8
);
  logic                 byte_valid;
  logic [DataWidth-1:0] byte_data;
  logic                 byte_ready;
  logic                 pm_wr_en;
  logic [AddWidth-1:0]  pm_addr;
  logic [DataWidth-1:0] pm_wr_data;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output pm_wr_en,
    output pm_addr,
    output pm_wr_data
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  pm_wr_en,
    input  pm_addr,
    input  pm_wr_data
  );
endinterface

// File: rtl/pm_boot_loader.sv
// Boot/load sequencer: streams an image into program memory from address 0 upward,
// holds the CPU in reset while loading and releases it when the image is complete.
// Optional feature: define PM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte
// (CKSUM state); without it the flow is LOAD -> RELEASE -> RUN.
// All outputs are registered; status flags are computed from the next state.
module pm_boot_loader #(
  parameter int unsigned AddWidth  = 7,
  parameter int unsigned DataWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_start_i,
  input  logic [AddWidth:0]   load_len_i,
  input  logic                stop_i,
  pm_boot_loader_if.slave     ldr_if,
  output logic                cpu_rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifdef PM_BOOT_CHECKSUM_EN
    StCksum,
`endif
    StRelease,
    StRun
  } state_e;

  // Largest legal image: 2**AddWidth bytes.
  localparam logic [AddWidth:0] LenMax = {1'b1, {AddWidth{1'b0}}};

  state_e               state_q, state_d;
  logic [AddWidth:0]    cnt_q, cnt_d;
  logic [AddWidth:0]    len_q, len_d;
  logic                 err_q, err_d;
  logic                 wr_en_q, wr_en_d;
  logic [AddWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cpu_rst_q, cpu_rst_d;
`ifdef PM_BOOT_CHECKSUM_EN
  logic [DataWidth-1:0] csum_q, csum_d;
`endif

  logic accept;
  logic len_ok;
  logic last_byte;

  assign accept    = ldr_if.byte_valid & rdy_q;
  assign len_ok    = (load_len_i != '0) && (load_len_i <= LenMax);
  assign last_byte = (cnt_q == len_q - 1'b1);

  // Next-state, counters, write path and registered status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef PM_BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          if (len_ok) begin
            state_d = StLoad;
            len_d   = load_len_i;
            cnt_d   = '0;
            err_d   = 1'b0;
`ifdef PM_BOOT_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // stop wins over a same-cycle accept: that byte is dropped.
        if (stop_i) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (accept) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q[AddWidth-1:0];
          data_d  = ldr_if.byte_data;
          cnt_d   = cnt_q + 1'b1;
`ifdef PM_BOOT_CHECKSUM_EN
          csum_d  = csum_q ^ ldr_if.byte_data;
          if (last_byte) state_d = StCksum;
`else
          if (last_byte) state_d = StRelease;
`endif
        end
      end
`ifdef PM_BOOT_CHECKSUM_EN
      StCksum: begin
        // Checksum byte is compared only, never written to program memory.
        if (stop_i) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (accept) begin
          if (ldr_if.byte_data == csum_q) begin
            state_d = StRun;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
`endif
      StRelease: begin
        // Final write is on the bus this cycle; CPU not yet released, so stop aborts.
        if (stop_i) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef PM_BOOT_CHECKSUM_EN
    rdy_d  = (state_d == StLoad) || (state_d == StCksum);
    busy_d = (state_d == StLoad) || (state_d == StCksum) || (state_d == StRelease);
`else
    rdy_d  = (state_d == StLoad);
    busy_d = (state_d == StLoad) || (state_d == StRelease);
`endif
    done_d    = (state_d == StRun);
    cpu_rst_d = (state_d != StRun);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
`ifdef PM_BOOT_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef PM_BOOT_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign ldr_if.byte_ready = rdy_q;
  assign ldr_if.pm_wr_en   = wr_en_q;
  assign ldr_if.pm_addr    = addr_q;
  assign ldr_if.pm_wr_data = data_q;
  assign cpu_rst_o         = cpu_rst_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_pm_boot_loader.sv
// Bench for pm_boot_loader: per-cycle vector table plus hand sequences for the
// maximum-length image and an asynchronous reset in the middle of a load.
module tb_pm_boot_loader;

`ifdef PM_BOOT_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  typedef enum int {EIdle, ELoad, ECk, ERel, ERun} est_t;

  typedef struct {
    logic       ls;
    logic [7:0] len;
    logic       stp;
    logic       bv;
    logic [7:0] bd;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
    est_t       st;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic load_start;
  logic [7:0] load_len;
  logic stop;
  logic cpu_rst, busy, done, err;
  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pm_boot_loader_if #(.AddWidth(7), .DataWidth(8)) ifc ();

  pm_boot_loader #(.AddWidth(7), .DataWidth(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .load_start_i(load_start),
    .load_len_i  (load_len),
    .stop_i      (stop),
    .ldr_if      (ifc),
    .cpu_rst_o   (cpu_rst),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  // Expected {cpu_rst, busy, done, byte_ready} for each loader state.
  function automatic logic [3:0] status(input est_t s);
    case (s)
      EIdle:   return 4'b1000;
      ELoad:   return 4'b1101;
      ECk:     return 4'b1101;
      ERel:    return 4'b1100;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pv(input logic ls, input logic [7:0] len, input logic stp, input logic bv,
                    input logic [7:0] bd, input logic wr, input logic [6:0] addr,
                    input logic [7:0] data, input est_t st, input logic e);
    vec_t v;
    v.ls = ls; v.len = len; v.stp = stp; v.bv = bv; v.bd = bd;
    v.wr = wr; v.addr = addr; v.data = data; v.st = st; v.err = e;
    vq.push_back(v);
  endtask

  task automatic idle(input est_t st, input logic e);
    pv(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0, st, e);
  endtask

  task automatic start(input logic [7:0] len, input est_t st, input logic e);
    pv(1'b1, len, 1'b0, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0, st, e);
  endtask

  task automatic stop_v(input est_t st, input logic e);
    pv(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0, st, e);
  endtask

  // Program byte preceded by 'gaps' idle cycles; the last one leaves LOAD.
  task automatic byte_in(input logic [7:0] d, input logic [6:0] a, input bit last,
                         input int gaps);
    for (int g = 0; g < gaps; g++) idle(ELoad, 1'b0);
    pv(1'b0, 8'd0, 1'b0, 1'b1, d, 1'b1, a, d, last ? (CkEn ? ECk : ERel) : ELoad, 1'b0);
  endtask

  // Checksum byte (checksum build) or the RELEASE->RUN cycle (default build).
  task automatic finish(input logic [7:0] ck, input bit good);
    if (CkEn) pv(1'b0, 8'd0, 1'b0, 1'b1, ck, 1'b0, 7'd0, 8'd0, good ? ERun : EIdle, !good);
    else idle(ERun, 1'b0);
  endtask

  initial begin
    logic [20:0] exp_v, obs_v;
    logic [7:0] d, ck;
    rst_ni = 1'b0;
    load_start = 1'b0;
    load_len = '0;
    stop = 1'b0;
    ifc.byte_valid = 1'b0;
    ifc.byte_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {ifc.pm_wr_en, ifc.pm_addr, ifc.pm_wr_data, cpu_rst, busy, done,
                    ifc.byte_ready, err}, {1'b0, 7'd0, 8'd0, 4'b1000, 1'b0});
    rst_ni = 1'b1;

    // Back-to-back image, load_start ignored in RUN, stop from RUN.
    start(8'd4, ELoad, 1'b0);
    byte_in(8'h13, 7'd0, 0, 0);
    byte_in(8'h05, 7'd1, 0, 0);
    byte_in(8'hA0, 7'd2, 0, 0);
    byte_in(8'h00, 7'd3, 1, 0);
    finish(8'hB6, 1);
    start(8'd3, ERun, 1'b0);
    stop_v(EIdle, 1'b0);
    // Same image with 3-cycle bubbles.
    start(8'd4, ELoad, 1'b0);
    byte_in(8'h13, 7'd0, 0, 0);
    byte_in(8'h05, 7'd1, 0, 3);
    byte_in(8'hA0, 7'd2, 0, 3);
    byte_in(8'h00, 7'd3, 1, 3);
    finish(8'hB6, 1);
    stop_v(EIdle, 1'b0);
    // Illegal lengths, stream ignored in IDLE, stop in IDLE, then len=1 clears err.
    start(8'd0, EIdle, 1'b1);
    pv(1'b0, 8'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 7'd0, 8'd0, EIdle, 1'b1);
    start(8'd129, EIdle, 1'b1);
    stop_v(EIdle, 1'b1);
    start(8'd1, ELoad, 1'b0);
    byte_in(8'h5A, 7'd0, 1, 0);
    finish(8'h5A, 1);
    stop_v(EIdle, 1'b0);
    // len=8, load_start while busy ignored, stop after 3 accepts drops the 4th byte.
    start(8'd8, ELoad, 1'b0);
    byte_in(8'h11, 7'd0, 0, 0);
    pv(1'b1, 8'd1, 1'b0, 1'b1, 8'h22, 1'b1, 7'd1, 8'h22, ELoad, 1'b0);
    byte_in(8'h33, 7'd2, 0, 0);
    pv(1'b0, 8'd0, 1'b1, 1'b1, 8'h44, 1'b0, 7'd0, 8'd0, EIdle, 1'b1);
    pv(1'b0, 8'd0, 1'b0, 1'b1, 8'h55, 1'b0, 7'd0, 8'd0, EIdle, 1'b1);
    // Fresh load after an abort.
    start(8'd2, ELoad, 1'b0);
    byte_in(8'hAA, 7'd0, 0, 0);
    byte_in(8'h55, 7'd1, 1, 0);
    finish(8'hFF, 1);
    stop_v(EIdle, 1'b0);
`ifdef PM_BOOT_CHECKSUM_EN
    start(8'd3, ELoad, 1'b0);
    byte_in(8'h01, 7'd0, 0, 0);
    byte_in(8'h02, 7'd1, 0, 0);
    byte_in(8'h04, 7'd2, 1, 0);
    finish(8'h07, 1);
    stop_v(EIdle, 1'b0);
    start(8'd3, ELoad, 1'b0);
    byte_in(8'h01, 7'd0, 0, 0);
    byte_in(8'h02, 7'd1, 0, 0);
    byte_in(8'h04, 7'd2, 1, 0);
    finish(8'h06, 0);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      load_start = vq[i].ls;
      load_len = vq[i].len;
      stop = vq[i].stp;
      ifc.byte_valid = vq[i].bv;
      ifc.byte_data = vq[i].bd;
      step();
      exp_v = {vq[i].wr, vq[i].wr ? vq[i].addr : 7'd0, vq[i].wr ? vq[i].data : 8'd0,
               status(vq[i].st), vq[i].err};
      obs_v = {ifc.pm_wr_en, vq[i].wr ? ifc.pm_addr : 7'd0,
               vq[i].wr ? ifc.pm_wr_data : 8'd0, cpu_rst, busy, done, ifc.byte_ready, err};
      check($sformatf("vec%0d", i), {11'd0, obs_v}, {11'd0, exp_v});
    end
    load_start = 1'b0;
    stop = 1'b0;
    ifc.byte_valid = 1'b0;

    // Maximum-length image: 128 bytes, last address 127, no wrap.
    load_start = 1'b1;
    load_len = 8'd128;
    step();
    load_start = 1'b0;
    check("max_start", {30'd0, busy, ifc.byte_ready}, 32'd3);
    ck = 8'd0;
    for (int i = 0; i < 128; i++) begin
      d = i[7:0] ^ 8'h5C;
      ck = ck ^ d;
      ifc.byte_valid = 1'b1;
      ifc.byte_data = d;
      step();
      check($sformatf("max_wr%0d", i), {16'd0, ifc.pm_wr_en, ifc.pm_addr, ifc.pm_wr_data},
            {16'd0, 1'b1, i[6:0], d});
    end
    ifc.byte_valid = CkEn;
    ifc.byte_data = ck;
    step();
    ifc.byte_valid = 1'b0;
    check("max_run", {28'd0, cpu_rst, done, busy, ifc.pm_wr_en}, {28'd0, 4'b0100});
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("max_stop", {30'd0, cpu_rst, done}, {30'd0, 2'b10});

    // Asynchronous reset in the middle of a load.
    load_start = 1'b1;
    load_len = 8'd8;
    step();
    load_start = 1'b0;
    ifc.byte_valid = 1'b1;
    ifc.byte_data = 8'hC3;
    step();
    ifc.byte_data = 8'h3C;
    step();
    ifc.byte_valid = 1'b0;
    check("mid_wr", {16'd0, ifc.pm_wr_en, ifc.pm_addr, ifc.pm_wr_data},
          {16'd0, 1'b1, 7'd1, 8'h3C});
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst", {ifc.pm_wr_en, ifc.pm_addr, ifc.pm_wr_data, cpu_rst, busy, done,
                        ifc.byte_ready, err}, {1'b0, 7'd0, 8'd0, 4'b1000, 1'b0});
    step();
    rst_ni = 1'b1;
    step();
    check("post_rst", {27'd0, cpu_rst, busy, done, ifc.byte_ready, err}, {27'd0, 5'b10000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
